// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for four requesters, driving the select/enable of a 2-to-4 decoder.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no grant; pick the next requester searching from ptr
// GRANT | owner in sel_q holds the resource until release, request drop or timeout
module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       release_i,
  output logic       en_o,
  output logic       a0_o,
  output logic       a1_o,
  output logic [3:0] gnt_o,
  output logic       busy_o,
  output logic       timeout_o
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_param_err
    $error("rr_decoder_arbiter: illegal MAX_HOLD/CNT_W combination");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic       en_q, en_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] pick_idx;
  logic [1:0] scan_idx;
  logic       pick_found;
  logic       hit;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    pick_idx   = ptr_q;
    scan_idx   = ptr_q;
    pick_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!pick_found && req_i[scan_idx]) begin
        pick_idx   = scan_idx;
        pick_found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign hit = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD - 1));

  // A coincident release wins over the forced release, so no pulse then.
  always_comb begin
    cnt_d     = '0;
    timeout_d = 1'b0;
    if (state_q == GRANT) begin
      cnt_d     = cnt_q + 1'b1;
      timeout_d = hit && !release_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign hit       = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = GRANT;
          en_d    = 1'b1;
          sel_d   = pick_idx;
        end
      end
      GRANT: begin
        if (release_i || !req_i[sel_q] || hit) begin
          state_d = IDLE;
          en_d    = 1'b0;
          ptr_d   = sel_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Select lines stay put in IDLE, so the decoder only ever switches while disabled.
  assign en_o   = en_q;
  assign busy_o = en_q;
  assign a1_o   = sel_q[1];
  assign a0_o   = sel_q[0];
  assign gnt_o  = en_q ? (4'b0001 << sel_q) : 4'b0000;

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter that shares one resource among 4 requesters.
- Drives the select pair (A1,A0) and enable EN of the existing 2-to-4 enabled decoder stage. The decoder's D0..D3 outputs become the one-hot grant lines.
- Also exports its own registered one-hot grant for local use.
- Sits between the requesters and the decoder and owns all sequencing: selection, grant hold, release, and timeout.

Parameters:
- MAX_HOLD, 8, maximum number of cycles one grant may be held before forced release (only used when ARB_TIMEOUT_EN is defined); legal range 2..255.
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request lines, bit i = requester i; level-sensitive
- release  input  1  owner finished; single-cycle pulse, honoured only in GRANT
- EN  output  1  decoder enable; 1 while a grant is active
- A0  output  1  decoder select LSB = granted index bit 0
- A1  output  1  decoder select MSB = granted index bit 1
- gnt  output  4  one-hot grant = EN ? (1 << {A1,A0}) : 4'b0000
- busy  output  1  1 in GRANT state (equals EN)
- timeout  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (asynchronous, immediate, also mid-grant):
  - EN=0, A1A0=00, gnt=0000, busy=0, timeout=0.
  - Round-robin pointer ptr=0, hold counter=0, state=IDLE.
- Registers: EN, A1, A0, ptr, counter, state and timeout are all registered. gnt is decoded combinationally from the registered EN/A1/A0, so it is glitch-free relative to clk.
- FSM has two states, IDLE and GRANT:
  - IDLE: EN=0. If req!=0, select the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). Load it into {A1,A0}, set EN=1, clear the counter, and go to GRANT. If req==0, stay in IDLE; A1A0 holds its last value.
  - GRANT: EN=1 and the counter increments each cycle. Exit when any of the following occurs (all have equal effect):
    - (a) release=1
    - (b) req[owner]=0
    - (c) timeout, i.e. counter==MAX_HOLD-1 (only with ARB_TIMEOUT_EN)
  - On exit: EN=0 next cycle, ptr=owner+1 mod 4 (wraps 3 -> 0), state=IDLE. A1A0 keeps the old owner index.
- Latency and turnaround:
  - req sampled at edge N gives EN/gnt at edge N+1.
  - Exit condition at edge M gives EN=0 at M+1; the earliest next grant is at M+2.
  - The mandatory idle cycle gives a one-cycle turnaround so the decoder never switches outputs while EN=1.
- Simultaneous events:
  - release coincident with timeout: treated as a normal release, timeout is not pulsed.
  - release while in IDLE: ignored.
  - New requests arriving during GRANT: do not preempt; they are evaluated at the next IDLE cycle.
- Fairness: any continuously asserted requester is granted within 3 other grants.
- Outputs never hold X after reset; req containing X is not a legal input.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: the hold counter and MAX_HOLD limit are active. Force-release occurs after exactly MAX_HOLD cycles with EN=1, and timeout pulses high for 1 cycle coincident with the cycle EN falls to 0.
- Undefined: the counter logic is not built, a grant is held until release or request drop, and timeout is tied to 0. The port list is identical in both builds.

Test Plan:
- Reset check: assert rst_n=0 mid-grant -> EN, gnt, A1A0, busy and timeout go to 0 immediately, without waiting for a clk edge. Release reset with req=0000 -> EN stays 0.
- Single requester: req=0100 -> one edge later EN=1, {A1,A0}=10, gnt=0100. Pulse release -> EN=0 next edge, then gnt=0100 again after the idle cycle because req is still set.
- Round-robin rotation: req=1111 held, release pulsed each grant -> grant order 0,1,2,3,0. gnt sequence 0001,0010,0100,1000,0001 separated by idle cycles of gnt=0000.
- Pointer wrap and skip: owner=3 released with req=1010 -> next grant is 1 (gnt=0010), and ptr becomes 0 after that release.
- Request drop: grant 2 active, deassert req[2] without release -> EN=0 next edge and ptr=3.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): req=0001 held, no release -> EN high for exactly 8 cycles, timeout=1 for 1 cycle, then regrant to 0 after the idle cycle. Without the macro: EN stays high for 100+ cycles and timeout stays 0.
